dm_lsu: RTL and testbench
=========================

Name: dm_lsu

Overview:
Load/store unit that acts as initiator toward the 32-word data memory. The memory has a combinational read, a write on posedge clk, and ports addr[4:0], wd, we and rd.
- Accepts byte, halfword and word loads/stores from the CPU datapath on a byte address.
- Performs read-modify-write for sub-word stores and sign/zero extension for loads.
- Flags misaligned accesses without touching memory.
- Sits between the execute stage and the data memory.

Parameters:
ADDR_W, 5, word-address width of the data memory; byte address width is ADDR_W+2.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset; synchronous, active-high.
req  in  1  access request; sampled only in IDLE.
wr  in  1  1 = store, 0 = load.
size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
addr  in  ADDR_W+2  byte address.
wdata  in  32  store data; low byte/half used for sub-word stores.
busy  out  1  high while state is not IDLE.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done: misaligned or reserved size.
rdata  out  32  load result; valid from the done cycle, held until the next load completes.
dm_addr  out  ADDR_W  word address to memory.
dm_wd  out  32  write data to memory.
dm_we  out  1  write enable to memory.
dm_rd  in  32  combinational read data from memory.

Behaviour:
- Reset: state IDLE. busy, done, err, dm_we = 0. rdata, dm_addr, dm_wd and all latched request fields = 0.
- Byte lanes are little-endian: byte k = bits [8k+7:8k]. Word address = addr[ADDR_W+1:2].
- States: IDLE, RD, WR, DONE.
- IDLE, with req=1: latch wr, size, uns, addr, wdata. Next state:
  - DONE with err=1 if size=11, or half with addr[0]=1, or word with addr[1:0]≠0.
  - else WR for a word store.
  - else RD for all loads and for sub-word stores.
- IDLE, with req=0: stay in IDLE.
- RD: dm_addr = latched word address. Register dm_rd into hold.
  - Load: extract the lane selected by addr[1:0]/size, extend per uns, write the result to rdata, then go to DONE.
  - Sub-word store: go to WR.
- WR: dm_we = 1 for exactly this cycle.
  - dm_wd = wdata for word stores.
  - Otherwise dm_wd = hold with the selected byte/half lane replaced by wdata[7:0]/[15:0].
  - Next state DONE.
- DONE: done = 1, err per latched check, then IDLE. err is cleared whenever done=0.
- Latency from the req-accept edge to done high:
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
  - error: 1 cycle.
- Back-to-back operation: a new req is accepted in the first IDLE cycle after DONE.
- req while busy is ignored, not queued. Inputs may change freely while busy.
- dm_we is never high outside WR and is forced 0 in any cycle where rst=1.
- Reset mid-operation aborts with no write and no done pulse. A write in progress during the reset cycle is suppressed.
- A misaligned or reserved access never asserts dm_we and leaves rdata unchanged.
- dm_addr holds the last latched word address in every state.

Decomposition:
- Shared package dm_pkg:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - state enum for IDLE/RD/WR/DONE.
  - ADDR_W default.
- One natural sub-module, dm_lane_mux (combinational): lane extract plus extend for loads, and lane merge for stores. Inputs: word, addr[1:0], size, uns, wdata.

Test Plan:
- Store word 0xDEADBEEF at addr 0x08 -> exactly one dm_we cycle with dm_addr=2, dm_wd=0xDEADBEEF; done 2 cycles after accept, err=0.
- After that store: load byte at 0x0B with uns=0 -> rdata 0xFFFFFFDE. Load byte at 0x08 with uns=1 -> rdata 0x000000EF.
- Store half 0x1234 at 0x0A over 0xDEADBEEF -> RD then WR, dm_wd=0x1234BEEF; done 3 cycles after accept. Load half at 0x0A with uns=0 -> rdata 0x00001234.
- Load word at 0x06 -> done and err=1 one cycle after accept, dm_we never high, rdata unchanged. Repeat with size=11 -> same response.
- Pulse req during busy with different addr/wdata -> ignored: memory and rdata reflect only the first request, and exactly one done pulse occurs.
- Assert rst during RD of a sub-word store to 0x09 -> no dm_we, no done; word 2 is unchanged on readback, and all outputs take reset values on the next edge.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared size codes, FSM states and alignment check for the load/store unit
package dm_pkg;
    localparam int DM_ADDR_W = 5;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
        return (sz == SZ_RSVD) || (sz == SZ_HALF && lane[0]) || (sz == SZ_WORD && lane != 2'b00);
    endfunction
endpackage

// File: rtl/dm_lsu_if.sv
// dm_lsu_if: CPU-side request/response bus of the load/store unit
//   master (execute stage): drives req, wr, size, uns, addr, wdata; sees busy, done, err, rdata
//   slave (dm_lsu): the reverse
interface dm_lsu_if import dm_pkg::*; #(parameter int ADDR_W = DM_ADDR_W);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    modport master (output req, wr, size, uns, addr, wdata, input busy, done, err, rdata);
    modport slave (input req, wr, size, uns, addr, wdata, output busy, done, err, rdata);
endinterface

// File: rtl/dm_lane_mux.sv
// dm_lane_mux: little-endian lane extract/extend for loads and lane merge for stores
//   i_word: memory word, i_lane: addr[1:0], i_size/i_uns: access size and zero-extend flag
//   i_wdata: store data; o_load: extended load value; o_merge: word with lane replaced
module dm_lane_mux import dm_pkg::*; (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    logic [4:0]  w_sh;
    logic [15:0] w_lane;
    logic [31:0] w_mask;
    always_comb begin
        w_sh    = {i_lane, 3'b000};
        w_lane  = 16'(i_word >> w_sh);
        w_mask  = (i_size == SZ_BYTE) ? 32'h0000_00FF << w_sh :
                  (i_size == SZ_HALF) ? 32'h0000_FFFF << w_sh : 32'hFFFF_FFFF;
        o_load  = (i_size == SZ_BYTE) ? {{24{~i_uns & w_lane[7]}}, w_lane[7:0]} :
                  (i_size == SZ_HALF) ? {{16{~i_uns & w_lane[15]}}, w_lane} : i_word;
        o_merge = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
    end
endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit driving a 32-word data memory with sub-word read-modify-write
//   clk/rst: clock and synchronous active-high reset
//   bus: CPU request/response (dm_lsu_if.slave)
//   o_dm_addr/o_dm_wd/o_dm_we: memory word address, write data, write enable
//   i_dm_rd: combinational memory read data
module dm_lsu import dm_pkg::*; #(parameter int ADDR_W = DM_ADDR_W) (
    input  logic              clk,
    input  logic              rst,
    dm_lsu_if.slave           bus,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [31:0]       o_dm_wd,
    output logic              o_dm_we,
    input  logic [31:0]       i_dm_rd
);
    state_e            r_state, w_next;
    logic              r_wr, r_uns, r_err;
    logic [1:0]        r_size;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata, r_hold, r_rdata;
    logic [31:0]       w_word, w_load, w_merge;
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.req)
                w_next = misaligned(bus.size, bus.addr[1:0]) ? DONE :
                         (bus.wr && bus.size == SZ_WORD) ? WR : RD;
            RD:   w_next = r_wr ? WR : DONE;
            WR:   w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && bus.req) begin
                r_wr    <= bus.wr;
                r_uns   <= bus.uns;
                r_err   <= misaligned(bus.size, bus.addr[1:0]);
                r_size  <= bus.size;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (r_state == RD) begin
                r_hold <= i_dm_rd;
                if (!r_wr)
                    r_rdata <= w_load;
            end
        end
    end
    // loads extract straight from memory in RD; stores merge into the word held from RD
    assign w_word = (r_state == RD) ? i_dm_rd : r_hold;
    dm_lane_mux u_lane (
        .i_word (w_word),
        .i_lane (r_addr[1:0]),
        .i_size (r_size),
        .i_uns  (r_uns),
        .i_wdata(r_wdata),
        .o_load (w_load),
        .o_merge(w_merge)
    );
    assign o_dm_addr = r_addr[ADDR_W+1:2];
    assign o_dm_we   = (r_state == WR) && !rst;
    assign o_dm_wd   = (r_state == WR) ? w_merge : '0;
    assign bus.busy  = r_state != IDLE;
    assign bus.done  = r_state == DONE;
    assign bus.err   = (r_state == DONE) && r_err;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: randomized + directed bench for dm_lsu against a transaction-level model
module tb_dm_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wd, dm_rd;
    logic        dm_we;
    int          n_cmp = 0, n_bad = 0, n_we = 0;
    bit          chk_en = 1'b0;

    dm_lsu_if #(.ADDR_W(5)) bus();
    dm_lsu #(.ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_dm_addr(dm_addr), .o_dm_wd(dm_wd), .o_dm_we(dm_we), .i_dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wd;
    always @(posedge clk) if (dm_we) n_we++;
    assign dm_rd = mem[dm_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level model: position within the current access and its outcome
    logic [31:0] ref_mem [32];
    int          m_pos = 0, m_lat = 0, off;
    logic        m_wr = 0, m_err = 0;
    logic [4:0]  m_waddr = 0;
    logic [31:0] m_rdata = 0, m_load = 0, m_new = 0;
    logic [7:0]  b [4];

    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0; m_lat = 0; m_wr = 0; m_err = 0; m_waddr = 0; m_rdata = 0;
        end else if (m_pos == 0) begin
            if (bus.req) begin
                off     = int'(bus.addr[1:0]);
                m_wr    = bus.wr;
                m_waddr = bus.addr[6:2];
                m_err   = bus.size == 3 || (bus.size == 1 && off % 2 != 0) || (bus.size == 2 && off != 0);
                m_lat   = m_err ? 1 : (!bus.wr || bus.size == 2) ? 2 : 3;
                for (int i = 0; i < 4; i++) b[i] = ref_mem[m_waddr][8*i +: 8];
                m_load = 0;
                m_new  = 0;
                if (!m_err) begin
                    if (bus.size == 0) m_load = {{24{!bus.uns && b[off][7]}}, b[off]};
                    else if (bus.size == 1) m_load = {{16{!bus.uns && b[off+1][7]}}, b[off+1], b[off]};
                    else m_load = ref_mem[m_waddr];
                    if (bus.size == 2) m_new = bus.wdata;
                    else begin
                        b[off] = bus.wdata[7:0];
                        if (bus.size == 1) b[off+1] = bus.wdata[15:8];
                        m_new = {b[3], b[2], b[1], b[0]};
                    end
                end
                m_pos = 1;
            end
        end else begin
            if (m_wr && !m_err && m_pos == m_lat - 1) ref_mem[m_waddr] = m_new;
            if (m_pos == m_lat) m_pos = 0;
            else begin
                m_pos++;
                if (m_pos == m_lat && !m_wr && !m_err) m_rdata = m_load;
            end
        end
    end

    logic exp_done, exp_we;
    always @(negedge clk) if (chk_en) begin
        exp_done = m_pos != 0 && m_pos == m_lat;
        exp_we   = m_pos != 0 && m_wr && !m_err && m_pos == m_lat - 1 && !rst;
        chk("busy", bus.busy, m_pos != 0);
        chk("done", bus.done, exp_done);
        chk("err", bus.err, exp_done && m_err);
        chk("rdata", bus.rdata, m_rdata);
        chk("dm_addr", dm_addr, m_waddr);
        chk("dm_we", dm_we, exp_we);
        if (exp_we) chk("dm_wd", dm_wd, m_new);
    end

    task automatic op(input logic w, input logic [1:0] s, input logic u, input logic [6:0] a,
                      input logic [31:0] d, input bit junk, input int abort_at,
                      output int lat, output logic e);
        int n;
        lat = 0; e = 0; n = 0;
        while (bus.busy && n < 20) begin @(posedge clk); #1; n++; end
        chk("idle_wait", bus.busy, 0);
        bus.req = 1; bus.wr = w; bus.size = s; bus.uns = u; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 0; bus.addr = 7'($urandom); bus.wdata = $urandom;
        for (n = 1; n < 10; n++) begin
            if (abort_at == n - 1) begin
                rst = 1; @(posedge clk); #1; rst = 0;
                return;
            end
            if (bus.done) break;
            if (junk) begin
                bus.req = 1; bus.wr = 1'($urandom); bus.size = 2'($urandom);
                bus.addr = 7'($urandom); bus.wdata = $urandom;
            end
            @(posedge clk); #1;
            bus.req = 0;
        end
        chk("done_wait", bus.done, 1);
        lat = n; e = bus.err;
    endtask

    initial begin
        int lat, we0, ab;
        logic e, w, u, junk;
        logic [1:0] s;
        logic [6:0] a;
        bus.req = 0; bus.wr = 0; bus.size = 0; bus.uns = 0; bus.addr = 0; bus.wdata = 0;
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            mem[i] <= ref_mem[i];
        end
        @(posedge clk);
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_dm_wd", dm_wd, 0);

        we0 = n_we;
        op(1, 2'd2, 0, 7'h08, 32'hDEADBEEF, 0, -1, lat, e);
        chk("stw_lat", lat, 2); chk("stw_err", e, 0);
        chk("stw_mem", mem[2], 32'hDEADBEEF); chk("stw_we_cnt", n_we - we0, 1);
        op(0, 2'd0, 0, 7'h0B, 0, 0, -1, lat, e);
        chk("ldb_s_lat", lat, 2); chk("ldb_s", bus.rdata, 32'hFFFFFFDE);
        op(0, 2'd0, 1, 7'h08, 0, 0, -1, lat, e);
        chk("ldb_u", bus.rdata, 32'h000000EF);
        we0 = n_we;
        op(1, 2'd1, 0, 7'h0A, 32'h00001234, 0, -1, lat, e);
        chk("sth_lat", lat, 3); chk("sth_mem", mem[2], 32'h1234BEEF); chk("sth_we_cnt", n_we - we0, 1);
        op(0, 2'd1, 0, 7'h0A, 0, 0, -1, lat, e);
        chk("ldh", bus.rdata, 32'h00001234);
        we0 = n_we;
        op(0, 2'd2, 0, 7'h06, 0, 0, -1, lat, e);
        chk("mis_lat", lat, 1); chk("mis_err", e, 1); chk("mis_rdata", bus.rdata, 32'h00001234);
        op(0, 2'd3, 0, 7'h08, 0, 0, -1, lat, e);
        chk("rsv_lat", lat, 1); chk("rsv_err", e, 1); chk("rsv_rdata", bus.rdata, 32'h00001234);
        chk("err_we_cnt", n_we - we0, 0);
        we0 = n_we;
        op(1, 2'd2, 0, 7'h10, 32'hCAFEF00D, 1, -1, lat, e);
        chk("junk_st_lat", lat, 2); chk("junk_mem", mem[4], 32'hCAFEF00D); chk("junk_we_cnt", n_we - we0, 1);
        op(0, 2'd2, 0, 7'h10, 0, 1, -1, lat, e);
        chk("junk_ld", bus.rdata, 32'hCAFEF00D);
        we0 = n_we;
        op(1, 2'd0, 0, 7'h09, 32'h00000055, 0, 0, lat, e);
        chk("abort_busy", bus.busy, 0); chk("abort_done", bus.done, 0);
        chk("abort_rdata", bus.rdata, 0); chk("abort_dm_addr", dm_addr, 0);
        chk("abort_dm_we", dm_we, 0); chk("abort_dm_wd", dm_wd, 0);
        chk("abort_we_cnt", n_we - we0, 0); chk("abort_mem", mem[2], 32'h1234BEEF);
        op(0, 2'd2, 0, 7'h08, 0, 0, -1, lat, e);
        chk("abort_readback", bus.rdata, 32'h1234BEEF);

        for (int k = 0; k < 300; k++) begin
            w = 1'($urandom); u = 1'($urandom); s = 2'($urandom); a = 7'($urandom);
            if ($urandom_range(0, 2) != 0) a = a & (s == 2 ? 7'h7C : s == 1 ? 7'h7E : 7'h7F);
            junk = 1'($urandom);
            ab = ($urandom_range(0, 25) == 0) ? int'($urandom_range(0, 3)) : -1;
            op(w, s, u, a, $urandom, junk, ab, lat, e);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 32; i++) chk("mem_final", mem[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
